// File: rtl/sdr_to_ddr_tx.sv
// Purpose : buffers 2-bit SDR words in a small FIFO and drives them onto one DDR pad (bit0 high phase, bit1 low phase).
// Latency : a burst starts on the edge after occupancy reaches START_LEVEL; the word is on the pad one edge later.
// Backpressure: ready_o drops when the FIFO is full, when enable is low, or while reset_n is asserted.
//
// Ports:
//   clk_i          clock for FIFO, FSM and the DDR output register
//   reset_n        asynchronous active-low reset
//   enable         global clock enable; low freezes everything, including the pad register
//   data_i/valid_i/ready_o   SDR word input handshake; a push is valid_i & ready_o
//   data_o         DDR pad output
//   busy_o         high while a burst is being sent
//   fifo_count_o   registered FIFO occupancy
//   underrun_cnt_o saturating count of bursts that ended on an empty FIFO
module sdr_to_ddr_tx #(
    parameter int         DEPTH        = 4,
    parameter int         START_LEVEL  = 2,
    parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [1:0]              data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    data_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  fifo_count_o,
    output logic [7:0]              underrun_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] START_C = CW'(START_LEVEL);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         r_state;
    logic [1:0]     r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [1:0]     r_tx;
    logic           r_busy;
    logic [7:0]     r_underrun;
    logic           r_ddr_hi;
    logic           r_ddr_lo;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_ddr_q;

    assign w_full  = (r_count == FULL_C);
    assign w_empty = (r_count == '0);

    // reset_n is folded in so ready_o reads 0 for the whole reset window,
    // and goes high on the first enabled cycle after release.
    assign ready_o = enable & reset_n & ~w_full;
    assign w_push  = valid_i & ready_o;

    // Pop decision mirrors the FSM: IDLE waits for the start level,
    // ACTIVE drains one word per clock until empty.
    assign w_pop = enable & ((r_state == IDLE) ? (r_count >= START_C) : ~w_empty);

    // Storage has no reset; emptiness is carried entirely by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // A pop reads r_mem at r_rd_ptr before this edge's write lands, so it
    // always returns the oldest entry, never the word being pushed now.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tx       <= IDLE_PATTERN;
            r_busy     <= 1'b0;
            r_underrun <= '0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx    <= r_mem[r_rd_ptr];
                        r_busy  <= 1'b1;
                        r_state <= ACTIVE;
                    end else begin
                        r_tx <= IDLE_PATTERN;
                    end
                end
                ACTIVE: begin
                    if (w_pop) begin
                        r_tx <= r_mem[r_rd_ptr];
                    end else begin
                        r_tx    <= IDLE_PATTERN;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        if (r_underrun != 8'hFF) begin
                            r_underrun <= r_underrun + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // O_DDR (D = r_tx, R = reset_n, E = enable, C = clk_i): both bits are
    // captured on the rising edge; the clock selects bit0 for the high
    // phase and bit1 for the low phase.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_ddr_hi <= 1'b0;
            r_ddr_lo <= 1'b0;
        end else if (enable) begin
            r_ddr_hi <= r_tx[0];
            r_ddr_lo <= r_tx[1];
        end
    end

    assign w_ddr_q = clk_i ? r_ddr_hi : r_ddr_lo;

    // O_BUF: pad driver.
    assign data_o = w_ddr_q;

    assign busy_o         = r_busy;
    assign fifo_count_o   = r_count;
    assign underrun_cnt_o = r_underrun;

endmodule

// File: tb/tb_sdr_to_ddr_tx.sv
// Bench for sdr_to_ddr_tx: directed vectors with hand-computed expectations.
// Two instances: START_LEVEL=2 (main) and START_LEVEL=4 (fills the FIFO completely).
// A per-instance pad monitor collects every word sent during a burst.
module tb_sdr_to_ddr_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       valid = 1'b0;
    logic       valid4 = 1'b0;
    logic [1:0] din = 2'b00;

    logic       ready, dout, busy;
    logic [2:0] cnt;
    logic [7:0] urun;
    logic       ready4, dout4, busy4;
    logic [2:0] cnt4;
    logic [7:0] urun4;

    int n_tests = 0;
    int n_fail  = 0;
    int errs;

    logic [1:0] rxq [$];
    logic [1:0] rxq4 [$];
    logic [1:0] exp_q [$];

    always #5 clk = ~clk;

    sdr_to_ddr_tx #(.DEPTH(4), .START_LEVEL(2), .IDLE_PATTERN(2'b00)) u_dut (
        .clk_i(clk), .reset_n(reset_n), .enable(enable),
        .data_i(din), .valid_i(valid), .ready_o(ready),
        .data_o(dout), .busy_o(busy),
        .fifo_count_o(cnt), .underrun_cnt_o(urun)
    );

    sdr_to_ddr_tx #(.DEPTH(4), .START_LEVEL(4), .IDLE_PATTERN(2'b00)) u_dut4 (
        .clk_i(clk), .reset_n(reset_n), .enable(enable),
        .data_i(din), .valid_i(valid4), .ready_o(ready4),
        .data_o(dout4), .busy_o(busy4),
        .fifo_count_o(cnt4), .underrun_cnt_o(urun4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [1:0] got[$], input logic [1:0] expw[$]);
        int bad;
        bad = 0;
        chk({tag, "_len"}, got.size(), expw.size());
        for (int i = 0; i < expw.size(); i++) begin
            if (i >= got.size()) bad++;
            else if (got[i] !== expw[i]) bad++;
        end
        chk({tag, "_order"}, bad, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pad monitor: a word is data when busy_o was high after the previous
    // enabled edge (that edge loaded tx with a popped word).
    logic m_hi, m_cap, m_lastb;
    logic m4_hi, m4_cap, m4_lastb;

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            m_lastb = 1'b0;
            m_cap   = 1'b0;
            m_hi    = 1'b0;
        end else if (enable) begin
            m_hi    = dout;
            m_cap   = m_lastb;
            m_lastb = busy;
        end else begin
            m_cap = 1'b0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (m_cap && reset_n) rxq.push_back({dout, m_hi});
    end

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            m4_lastb = 1'b0;
            m4_cap   = 1'b0;
            m4_hi    = 1'b0;
        end else if (enable) begin
            m4_hi    = dout4;
            m4_cap   = m4_lastb;
            m4_lastb = busy4;
        end else begin
            m4_cap = 1'b0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (m4_cap && reset_n) rxq4.push_back({dout4, m4_hi});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        ticks(3);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_underrun", 32'(urun), 0);
        chk("rst_pad_hi", 32'(dout), 0);
        @(negedge clk); #1;
        chk("rst_pad_lo", 32'(dout), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(ready), 1);

        // ---------------- basic burst: 10, 01, 11 ----------------
        rxq.delete();
        valid = 1'b1;
        din = 2'b10; tick();
        din = 2'b01; tick();
        din = 2'b11; tick();
        valid = 1'b0;
        chk("t1_busy_rise", 32'(busy), 1);
        chk("t1_count", 32'(cnt), 2);
        ticks(3);
        chk("t1_busy_fall", 32'(busy), 0);
        chk("t1_underrun", 32'(urun), 1);
        ticks(2);
        chk("t1_idle_pad", 32'(dout), 0);
        exp_q.delete();
        exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b11);
        cmp_q("t1", rxq, exp_q);

        // ---------------- full FIFO + enable stall (START_LEVEL=4) ----------------
        rxq4.delete();
        valid4 = 1'b1;
        din = 2'b01; tick();
        din = 2'b10; tick();
        din = 2'b11; tick();
        din = 2'b00; tick();
        chk("t2_full_cnt", 32'(cnt4), 4);
        chk("t2_full_rdy", 32'(ready4), 0);
        enable = 1'b0;
        din = 2'b10;
        ticks(3);
        chk("t2_stall_cnt", 32'(cnt4), 4);
        chk("t2_stall_rdy", 32'(ready4), 0);
        chk("t2_stall_busy", 32'(busy4), 0);
        chk("t2_main_rdy_low", 32'(ready), 0);
        enable = 1'b1;
        tick();
        chk("t2_resume_cnt", 32'(cnt4), 3);
        chk("t2_resume_busy", 32'(busy4), 1);
        tick();
        valid4 = 1'b0;
        chk("t2_push_pop_cnt", 32'(cnt4), 3);
        ticks(6);
        exp_q.delete();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        exp_q.push_back(2'b00); exp_q.push_back(2'b10);
        cmp_q("t2", rxq4, exp_q);
        chk("t2_underrun", 32'(urun4), 1);

        // ---------------- 100-word stream ----------------
        rxq.delete();
        exp_q.delete();
        errs = 0;
        valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din = 2'(i);
            exp_q.push_back(2'(i));
            if (!ready) errs++;
            tick();
        end
        valid = 1'b0;
        chk("t3_ready_held", errs, 0);
        ticks(6);
        cmp_q("t3", rxq, exp_q);
        chk("t3_underrun", 32'(urun), 2);

        // ---------------- push+pop at count 1 ----------------
        rxq.delete();
        exp_q.delete();
        errs = 0;
        valid = 1'b1;
        din = 2'b11; exp_q.push_back(2'b11); tick();
        din = 2'b00; exp_q.push_back(2'b00); tick();
        valid = 1'b0;
        tick();
        chk("t4_cnt_start", 32'(cnt), 1);
        valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 2'(k * 3 + 1);
            exp_q.push_back(2'(k * 3 + 1));
            tick();
            if (cnt != 3'd1) errs++;
        end
        valid = 1'b0;
        chk("t4_cnt_held", errs, 0);
        ticks(6);
        cmp_q("t4", rxq, exp_q);
        chk("t4_underrun", 32'(urun), 3);

        // ---------------- reset mid-burst ----------------
        rxq.delete();
        valid = 1'b1;
        din = 2'b01; tick();
        din = 2'b10; tick();
        din = 2'b00; tick();
        valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ready), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_count", 32'(cnt), 0);
        chk("t5_rst_underrun", 32'(urun), 0);
        chk("t5_rst_pad_hi", 32'(dout), 0);
        @(negedge clk); #1;
        chk("t5_rst_pad_lo", 32'(dout), 0);
        ticks(2);
        reset_n = 1'b1;
        tick();
        valid = 1'b1;
        din = 2'b11; tick();
        din = 2'b01; tick();
        valid = 1'b0;
        tick();
        chk("t5_pad_before", 32'(dout), 0);
        tick();
        chk("t5_lat_hi", 32'(dout), 1);
        @(negedge clk); #1;
        chk("t5_lat_lo", 32'(dout), 1);
        ticks(6);
        exp_q.delete();
        exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        cmp_q("t5", rxq, exp_q);
        chk("t5_underrun", 32'(urun), 1);

        // ---------------- underrun saturation ----------------
        for (int i = 0; i < 300; i++) begin
            valid = 1'b1;
            din = 2'(i);
            tick();
            tick();
            valid = 1'b0;
            ticks(4);
            if (i == 99)  chk("t6_mid", 32'(urun), 101);
            if (i == 252) chk("t6_pre_sat", 32'(urun), 254);
        end
        chk("t6_saturated", 32'(urun), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_to_ddr_tx.md
# sdr_to_ddr_tx

Transmit-side companion to the DDR receive path. Accepts 2-bit parallel SDR words over a valid/ready handshake and buffers them in a small FIFO. Words stream out one per clock through an O_DDR primitive and an O_BUF onto a single pad: bit 0 is sent in the high phase and bit 1 in the low phase of clk_i. Sits at the fabric-to-pad boundary, so it is the mirror of the DDR-to-SDR receive block on the far end of the link.

## Interface
- DEPTH, 4: FIFO depth in 2-bit words; power of two, at least 2.
- START_LEVEL, 2: FIFO occupancy that launches a burst from IDLE; range 1..DEPTH.
- IDLE_PATTERN, 2'b00: word driven on the pad when no data is being sent.
- clk_i  input  1  clock; drives FIFO, FSM and the O_DDR clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  global clock enable; low freezes the whole block.
- data_i  input  2  SDR word; [0] goes out first (high phase), [1] second (low phase).
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  1  DDR pad output, driven through O_BUF.
- busy_o  output  1  FSM is in ACTIVE.
- fifo_count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
- underrun_cnt_o  output  8  saturating count of bursts that ended on an empty FIFO.

## Operation
- Push: occurs when valid_i & ready_o. ready_o = enable & (count != DEPTH).
- Pointers: write and read pointers wrap modulo DEPTH. Count is kept at $clog2(DEPTH)+1 bits, so the full and empty states are distinct.
- tx_reg (2 bits) drives O_DDR D[1:0]. O_DDR R = reset_n, E = enable, C = clk_i.
- FSM states, reset state IDLE:
  - IDLE: tx_reg <= IDLE_PATTERN. If count >= START_LEVEL, pop one word into tx_reg on the same edge and go to ACTIVE.
  - ACTIVE: if count != 0, pop into tx_reg and stay. If count == 0, load IDLE_PATTERN into tx_reg, increment underrun_cnt (saturating at 255), and go to IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance. A pop always reads the oldest entry, never the word being pushed on the same edge.
- Push while full: cannot occur because ready_o is low. Writes are additionally gated by !full.
- enable low:
  - no push and no pop;
  - FSM, tx_reg, pointers and counters hold;
  - O_DDR holds its last output;
  - ready_o is 0.
- Reset, any time including mid-burst:
  - FIFO is emptied;
  - state goes to IDLE;
  - tx_reg = IDLE_PATTERN;
  - ready_o = 0, busy_o = 0, fifo_count_o = 0, underrun_cnt_o = 0, data_o = 0.
  - Words in flight are discarded, not transmitted.
- ready_o becomes 1 on the first enabled cycle after reset deasserts.

## Timing
- Push at edge N into an empty FIFO in IDLE with START_LEVEL = 1:
  - pop into tx_reg at edge N+1;
  - O_DDR captures tx_reg at edge N+2;
  - data_o = word[0] from posedge N+2 and word[1] from the following negedge.
  - Pad latency is 2 cycles plus pad and primitive delay.
- Generally, the burst starts on the edge after occupancy reaches START_LEVEL. After that, one word is sent per clock with no gaps while count > 0.
- busy_o rises on the edge that performs the first pop. It falls on the edge that loads IDLE_PATTERN after an underrun.
- underrun_cnt_o updates on that same falling edge of busy_o.
- fifo_count_o is registered and updates on the edge of each push or pop.
- Throughput: 1 word per clock sustained, provided valid_i stays high from before busy_o rises.

## Test plan
- Reset, then valid_i high with 2'b10, 2'b01, 2'b11 on consecutive cycles, START_LEVEL = 2 -> pad sequence from two cycles after the second push is 0,1 / 1,0 / 1,1 (bit0 in high phase, bit1 in low phase). After that, IDLE_PATTERN; busy_o falls and underrun_cnt_o = 1.
- Hold valid_i high with ready_o gated off by a stalled pop (enable toggled low after 4 pushes, DEPTH = 4) -> fifo_count_o = 4, ready_o = 0, no word lost. Words come out in order after enable returns high.
- Continuous streaming of 100 incrementing 2-bit words -> FIFO wraps many times. Every word appears on the pad exactly once, in order, back-to-back. underrun_cnt_o increments by 1 only at stream end.
- Simultaneous push and pop at count = 1 for 20 cycles -> fifo_count_o stays 1 and the pad stream matches the input delayed by the fixed latency.
- Assert reset_n mid-burst with 3 words queued -> all outputs are 0 asynchronously and the queued words are never sent. After release, a new word 2'b11 reaches the pad with the standard latency.
- Force 300 separate underruns -> underrun_cnt_o saturates at 255.
